// File: rtl/mseq_checker.sv
// Receive-side checker for the 5-bit m-sequence (x^5 + x^3 + 1) PN test stream.
//
// Hunts for five seed bits, verifies that the stream follows the recurrence
// x(n) = x(n-5) ^ x(n-3) for LOCK_MATCHES consecutive bits, then declares lock.
// While locked, a local reference free-runs from its own predictions, so
// received errors are flagged and counted without corrupting the reference.
// Too many errors inside one WINDOW-bit block drops lock and restarts the hunt.
module mseq_checker #(
   parameter int unsigned LOCK_MATCHES = 10,
   parameter int unsigned WINDOW       = 31,
   parameter int unsigned LOSS_ERRS    = 4,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             bit_err,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bit_count
);

   typedef enum logic [1:0] {
      StHunt,
      StSync,
      StLocked
   } state_e;

   // Widths sized to the documented parameter ranges.
   localparam int unsigned MatchW = 8;   // LOCK_MATCHES <= 255
   localparam int unsigned WinW   = 16;  // WINDOW <= 65535

   localparam logic [MatchW:0]  LockTarget  = (MatchW + 1)'(LOCK_MATCHES);
   localparam logic [WinW-1:0]  WinLast     = WinW'(WINDOW - 1);
   localparam logic [WinW:0]    LossTarget  = (WinW + 1)'(LOSS_ERRS);
   localparam logic [CNT_W-1:0] CntMax      = '1;
   localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

   state_e            state_q, state_d;
   logic [4:0]        sr_q, sr_d;
   logic [2:0]        fill_q, fill_d;
   logic [MatchW-1:0] match_cnt_q, match_cnt_d;
   logic [WinW-1:0]   win_cnt_q, win_cnt_d;
   logic [WinW-1:0]   win_err_q, win_err_d;
   logic              locked_q, locked_d;
   logic              bit_err_q, bit_err_d;
   logic [CNT_W-1:0]  err_count_q, err_count_d;
   logic [CNT_W-1:0]  bit_count_q, bit_count_d;

   // Prediction of the next bit from the last five bits held in sr.
   logic pred;
   logic match;
   logic err;
   logic [MatchW:0] match_next;
   logic [WinW:0]   win_err_next;

   assign pred         = sr_q[4] ^ sr_q[2];
   // The all-zero register is the LFSR lockup state and never a valid match.
   assign match        = (in_bit == pred) && (sr_q != 5'b00000);
   assign err          = in_bit ^ pred;
   assign match_next   = {1'b0, match_cnt_q} + (MatchW + 1)'(1);
   assign win_err_next = {1'b0, win_err_q} + (WinW + 1)'(err);

   // State register and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StHunt;
         sr_q        <= 5'b00000;
         fill_q      <= 3'd0;
         match_cnt_q <= '0;
         win_cnt_q   <= '0;
         win_err_q   <= '0;
         locked_q    <= 1'b0;
         bit_err_q   <= 1'b0;
         err_count_q <= '0;
         bit_count_q <= '0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         fill_q      <= fill_d;
         match_cnt_q <= match_cnt_d;
         win_cnt_q   <= win_cnt_d;
         win_err_q   <= win_err_d;
         locked_q    <= locked_d;
         bit_err_q   <= bit_err_d;
         err_count_q <= err_count_d;
         bit_count_q <= bit_count_d;
      end
   end

   // Next-state logic: everything holds unless a valid bit arrives.
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      fill_d      = fill_q;
      match_cnt_d = match_cnt_q;
      win_cnt_d   = win_cnt_q;
      win_err_d   = win_err_q;
      locked_d    = locked_q;
      bit_err_d   = 1'b0;
      err_count_d = err_count_q;
      bit_count_d = bit_count_q;

      if (in_valid) begin
         unique case (state_q)
            StHunt: begin
               sr_d   = {sr_q[3:0], in_bit};
               fill_d = fill_q + 3'd1;
               if (fill_q == 3'd4) begin
                  state_d     = StSync;
                  match_cnt_d = '0;
               end
            end

            StSync: begin
               // Received bits keep feeding sr, so a bad bit ages out in 5 bits.
               sr_d = {sr_q[3:0], in_bit};
               if (match) begin
                  match_cnt_d = match_next[MatchW-1:0];
                  if (match_next == LockTarget) begin
                     state_d   = StLocked;
                     locked_d  = 1'b1;
                     win_cnt_d = '0;
                     win_err_d = '0;
                  end
               end else begin
                  match_cnt_d = '0;
               end
            end

            StLocked: begin
               // Reference advances from its own prediction, not the input.
               sr_d      = {sr_q[3:0], pred};
               bit_err_d = err;
               if (bit_count_q != CntMax) begin
                  bit_count_d = bit_count_q + CntOne;
               end
               if (err && (err_count_q != CntMax)) begin
                  err_count_d = err_count_q + CntOne;
               end

               // Loss check takes precedence over the window rollover.
               if (win_err_next >= LossTarget) begin
                  state_d     = StHunt;
                  locked_d    = 1'b0;
                  fill_d      = 3'd0;
                  sr_d        = 5'b00000;
                  match_cnt_d = '0;
                  win_cnt_d   = '0;
                  win_err_d   = '0;
               end else if (win_cnt_q == WinLast) begin
                  win_cnt_d = '0;
                  win_err_d = '0;
               end else begin
                  win_cnt_d = win_cnt_q + WinW'(1);
                  win_err_d = win_err_next[WinW-1:0];
               end
            end

            default: begin
               state_d = StHunt;
            end
         endcase
      end

      // Counter clear wins over any increment in the same cycle.
      if (clr_cnt) begin
         err_count_d = '0;
         bit_count_d = '0;
      end
   end

   assign locked    = locked_q;
   assign bit_err   = bit_err_q;
   assign err_count = err_count_q;
   assign bit_count = bit_count_q;

endmodule

// File: tb/tb_mseq_checker.sv
// Directed bench for mseq_checker: lock acquisition, error flagging, windowed
// loss of lock, counter clear, asynchronous reset and gapped input.
module tb_mseq_checker;

   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_bit = 1'b0;
   logic             clr_cnt = 1'b0;
   logic             locked;
   logic             bit_err;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] bit_count;

   // Reference m-sequence generator state (x^5 + x^3 + 1).
   logic [4:0] g;
   int         n_vec = 0;
   int         n_err = 0;
   logic       seen_lock;

   mseq_checker #(
      .LOCK_MATCHES(10),
      .WINDOW      (31),
      .LOSS_ERRS   (4),
      .CNT_W       (CNT_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_bit   (in_bit),
      .clr_cnt  (clr_cnt),
      .locked   (locked),
      .bit_err  (bit_err),
      .err_count(err_count),
      .bit_count(bit_count)
   );

   always #5 clk = ~clk;

   task automatic next_gen(output logic b);
      b = g[4] ^ g[2];
      g = {g[3:0], b};
   endtask

   // Apply one cycle of inputs; return 1 time unit after the rising edge.
   task automatic tick(input logic vld, input logic b, input logic clr);
      in_valid = vld;
      in_bit   = b;
      clr_cnt  = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic send_gen(input logic flip, input logic clr);
      logic b;
      next_gen(b);
      tick(1'b1, b ^ flip, clr);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      g = 5'b00001;

      // Reset values while reset is held.
      @(negedge clk);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_bit_err", 32'(bit_err), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      check("rst_bit_count", 32'(bit_count), 32'd0);
      reset = 1'b0;

      // Clean stream: lock on the 15th valid bit.
      for (int i = 0; i < 14; i++) send_gen(1'b0, 1'b0);
      check("pre_lock_14", 32'(locked), 32'd0);
      send_gen(1'b0, 1'b0);
      check("lock_at_15", 32'(locked), 32'd1);
      check("lock_bit_err", 32'(bit_err), 32'd0);
      for (int i = 1; i <= 5; i++) begin
         send_gen(1'b0, 1'b0);
         check("bit_count_step", 32'(bit_count), 32'(i));
         check("clean_bit_err", 32'(bit_err), 32'd0);
      end

      // Single flipped bit: one pulse, no propagation into the reference.
      send_gen(1'b1, 1'b0);
      check("flip_bit_err", 32'(bit_err), 32'd1);
      check("flip_err_count", 32'(err_count), 32'd1);
      check("flip_locked", 32'(locked), 32'd1);
      for (int i = 0; i < 5; i++) begin
         send_gen(1'b0, 1'b0);
         check("after_flip_clean", 32'(bit_err), 32'd0);
      end
      check("after_flip_err_count", 32'(err_count), 32'd1);

      // Finish the 31-bit window so the earlier error is forgotten.
      for (int i = 0; i < 20; i++) send_gen(1'b0, 1'b0);
      check("win_end_locked", 32'(locked), 32'd1);

      // Clear with in_valid low: counters zero, lock untouched.
      tick(1'b0, 1'b0, 1'b1);
      check("clr_err_count", 32'(err_count), 32'd0);
      check("clr_bit_count", 32'(bit_count), 32'd0);
      check("clr_locked", 32'(locked), 32'd1);

      // Four errors in 16 bits: lock drops on the 4th.
      for (int k = 0; k < 4; k++) begin
         send_gen(1'b1, 1'b0);
         check("burst_bit_err", 32'(bit_err), 32'd1);
         check("burst_locked", 32'(locked), (k < 3) ? 32'd1 : 32'd0);
         if (k < 3) begin
            for (int i = 0; i < 4; i++) send_gen(1'b0, 1'b0);
         end
      end
      check("loss_err_count", 32'(err_count), 32'd4);
      check("loss_bit_count", 32'(bit_count), 32'd16);

      // Relock after 15 clean bits; counters retained.
      for (int i = 0; i < 14; i++) send_gen(1'b0, 1'b0);
      check("relock_pre", 32'(locked), 32'd0);
      send_gen(1'b0, 1'b0);
      check("relock", 32'(locked), 32'd1);
      check("relock_err_count", 32'(err_count), 32'd4);
      check("relock_bit_count", 32'(bit_count), 32'd16);

      // Clear in the same cycle as an error: clear wins.
      send_gen(1'b1, 1'b1);
      check("clr_vs_err_count", 32'(err_count), 32'd0);
      check("clr_vs_bit_count", 32'(bit_count), 32'd0);
      check("clr_vs_bit_err", 32'(bit_err), 32'd1);
      send_gen(1'b0, 1'b0);
      send_gen(1'b1, 1'b0);
      check("pre_rst_err_count", 32'(err_count), 32'd1);
      check("pre_rst_bit_count", 32'(bit_count), 32'd2);
      check("pre_rst_bit_err", 32'(bit_err), 32'd1);

      // Asynchronous reset mid-lock, away from any clock edge.
      #2;
      reset = 1'b1;
      #1;
      check("arst_locked", 32'(locked), 32'd0);
      check("arst_bit_err", 32'(bit_err), 32'd0);
      check("arst_err_count", 32'(err_count), 32'd0);
      check("arst_bit_count", 32'(bit_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 14; i++) send_gen(1'b0, 1'b0);
      check("arst_relock_pre", 32'(locked), 32'd0);
      send_gen(1'b0, 1'b0);
      check("arst_relock", 32'(locked), 32'd1);

      // All-zero input must never lock.
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      seen_lock = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick(1'b1, 1'b0, 1'b0);
         if (locked !== 1'b0) seen_lock = 1'b1;
      end
      check("zeros_never_locked", 32'(seen_lock), 32'd0);
      check("zeros_err_count", 32'(err_count), 32'd0);

      // Gapped input: valid every other cycle, lock after 29 clocks.
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      g = 5'b00001;
      for (int i = 0; i < 14; i++) begin
         send_gen(1'b0, 1'b0);
         tick(1'b0, 1'($urandom), 1'b0);
         check("gap_bit_err", 32'(bit_err), 32'd0);
      end
      check("gap_pre_lock_28clk", 32'(locked), 32'd0);
      send_gen(1'b0, 1'b0);
      check("gap_lock_29clk", 32'(locked), 32'd1);
      tick(1'b0, 1'($urandom), 1'b0);
      check("gap_idle_locked", 32'(locked), 32'd1);
      send_gen(1'b1, 1'b0);
      check("gap_flip_bit_err", 32'(bit_err), 32'd1);
      tick(1'b0, 1'($urandom), 1'b0);
      check("gap_idle_bit_err", 32'(bit_err), 32'd0);
      check("gap_err_count", 32'(err_count), 32'd1);
      check("gap_bit_count", 32'(bit_count), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
